audio_dac_arbiter: RTL and testbench
====================================

AUDIO_DAC_ARBITER -- requirements
Module: audio_dac_arbiter

Interface
REQ-001 Parameter: DW, 32, sample word width driven to the I2S transmitter.
REQ-002 Parameter: UW, 16, underrun counter width.
REQ-003 aud_bclk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 aud_lrc  input  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-006 en  input  1  arbiter enable; 0 = mute, no handshakes.
REQ-007 src0_valid  input  1  requester 0 has a sample.
REQ-008 src0_data  input  DW  requester 0 sample.
REQ-009 src0_ready  output  1  requester 0 sample accepted when valid & ready.
REQ-010 src1_valid, src1_data, src1_ready  as REQ-007..009 for requester 1.
REQ-011 dac_data  output  DW  sample for the next I2S slot, to the transmitter's dac_data.
REQ-012 grant  output  2  one-hot owner of the current stereo frame; 00 = none.
REQ-013 underrun_cnt  output  UW  count of slots sent as mute because no sample was fetched.

Function
REQ-014 lrc_edge = aud_lrc XOR aud_lrc_d0, where aud_lrc_d0 is aud_lrc registered on aud_bclk, reset to 0; identical to the transmitter's edge detect.
REQ-015 dac_data is a register; on every posedge with lrc_edge=1 it SHALL load 0, so the transmitter latches the pre-edge value and the register then holds mute until filled.
REQ-016 FSM states: S_IDLE, S_FETCH, S_HOLD.
REQ-017 S_IDLE: ready outputs 0; on lrc_edge with en=1 -> S_FETCH.
REQ-018 S_FETCH: the next slot is ~aud_lrc; the selected requester's ready = 1 (combinational from state and selection); on valid&ready, dac_data <= that data at the same edge, -> S_HOLD.
REQ-019 S_HOLD: ready outputs 0; on lrc_edge -> S_FETCH (en=1) or S_IDLE (en=0).
REQ-020 Frame start: the fetch started by an edge to aud_lrc=1 (next slot left) SHALL arbitrate; selection is re-evaluated every cycle in S_FETCH until acceptance.
REQ-021 Arbitration: exactly one valid -> that requester; both valid -> the one not granted in the last frame (round-robin pointer, reset to prefer src0); none -> no ready.
REQ-022 grant is updated to the winner on the left-slot acceptance edge and holds for the frame.
REQ-023 Right-slot fetch (edge to aud_lrc=0) SHALL offer ready only to the granted requester; grant=00 -> no ready, slot muted.
REQ-024 Never both ready outputs high in the same cycle.
REQ-025 Underrun: an lrc_edge while in S_FETCH SHALL increment underrun_cnt, saturating at all-ones, and restart S_FETCH for the new slot; the missed slot is transmitted as 0.
REQ-026 A missed left fetch leaves grant at 00 for that frame.
REQ-027 lrc_edge and acceptance in the same cycle: edge wins; data is not captured, ready treated as not asserted (no handshake), underrun counted.
REQ-028 en low: ready outputs forced 0 combinationally; next lrc_edge -> S_IDLE with grant <= 00; no underrun counted while en=0.
REQ-029 en rising: operation resumes at the next lrc_edge; the first fetch after an edge to aud_lrc=0 is a right slot with grant=00 and is muted.

Reset
REQ-030 On rst=1, asynchronously: state S_IDLE, aud_lrc_d0=0, dac_data=0, grant=00, round-robin pointer prefers src0, underrun_cnt=0; ready outputs 0.
REQ-031 rst asserted mid-fetch SHALL abort without a handshake; first fetch after release occurs on the first lrc_edge (immediately if aud_lrc=1 at release).

Verification
REQ-032 Only src0 valid, data L=0x11111111, R=0x22222222, 32 bclk per slot -> grant=01, transmitter gets L then R, one src0_ready pulse per slot, underrun_cnt=0.
REQ-033 Both valid continuously for 4 frames -> grant alternates 01,10,01,10; each frame's L/R from one source.
REQ-034 src1 valid withdrawn for the right slot of its frame -> that slot sends 0, underrun_cnt +1, src0 receives no ready during it.
REQ-035 Valid rises exactly on the lrc_edge cycle ending S_FETCH -> no capture, underrun_cnt +1, dac_data=0 for that slot.
REQ-036 underrun_cnt preset near all-ones via 0xFFFF+ missed slots with UW=16 -> holds at 0xFFFF.
REQ-037 rst pulsed mid-frame while src0_ready=1 -> all outputs reset values within the same cycle, no sample consumed, normal operation from the next lrc_edge.

Source files
------------

// File: rtl/audio_dac_arbiter.sv
// Two-requester sample arbiter for an I2S transmitter: fetches one sample per slot,
// grants a whole stereo frame to one source (round-robin) and counts muted slots.
module audio_dac_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned UW = 16
) (
    input  logic          aud_bclk,
    input  logic          rst,
    input  logic          aud_lrc,
    input  logic          en,
    input  logic          src0_valid,
    input  logic [DW-1:0] src0_data,
    output logic          src0_ready,
    input  logic          src1_valid,
    input  logic [DW-1:0] src1_data,
    output logic          src1_ready,
    output logic [DW-1:0] dac_data,
    output logic [1:0]    grant,
    output logic [UW-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          lrc_d0_q;
    logic [DW-1:0] dac_q, dac_d;
    logic [1:0]    grant_q, grant_d;
    logic          prio_q, prio_d;
    logic [UW-1:0] urun_q, urun_d;

    logic          lrc_edge;
    logic          left_fetch;
    logic [1:0]    sel;
    logic [1:0]    ready;
    logic          accept;
    logic          win;

    assign lrc_edge   = aud_lrc ^ lrc_d0_q;
    // While aud_lrc=1 the right slot is on the wire, so the sample being fetched is a left one.
    assign left_fetch = aud_lrc;

    always_comb begin
        sel = 2'b00;
        if (left_fetch) begin
            case ({src1_valid, src0_valid})
                2'b01:   sel = 2'b01;
                2'b10:   sel = 2'b10;
                2'b11:   sel = prio_q ? 2'b10 : 2'b01;
                default: sel = 2'b00;
            endcase
        end else begin
            sel = grant_q;
        end
    end

    // An lrc edge closes the slot, so no handshake may complete on that cycle.
    assign ready  = (state_q == S_FETCH && en && !lrc_edge) ? sel : 2'b00;
    assign accept = |(ready & {src1_valid, src0_valid});
    assign win    = ready[1];

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        urun_d  = urun_q;
        if (lrc_edge) begin
            dac_d = '0;
            if (!en) begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end else begin
                state_d = S_FETCH;
                if (aud_lrc) begin
                    grant_d = 2'b00;
                end
                if (state_q == S_FETCH && urun_q != '1) begin
                    urun_d = urun_q + 1'b1;
                end
            end
        end else if (accept) begin
            dac_d   = win ? src1_data : src0_data;
            state_d = S_HOLD;
            if (left_fetch) begin
                grant_d = ready;
                prio_d  = ~win;
            end
        end
    end

    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lrc_d0_q <= 1'b0;
            dac_q    <= '0;
            grant_q  <= 2'b00;
            prio_q   <= 1'b0;
            urun_q   <= '0;
        end else begin
            state_q  <= state_d;
            lrc_d0_q <= aud_lrc;
            dac_q    <= dac_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            urun_q   <= urun_d;
        end
    end

    assign src0_ready   = ready[0];
    assign src1_ready   = ready[1];
    assign dac_data     = dac_q;
    assign grant        = grant_q;
    assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_audio_dac_arbiter.sv
// Scenario bench for audio_dac_arbiter: queued sources, expected per-slot transmit words
// compared at every lrc edge, plus a narrow-counter instance for saturation.
module tb_audio_dac_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned UW = 16;

    logic          aud_bclk;
    logic          rst;
    logic          aud_lrc;
    logic          en;
    logic          src0_valid;
    logic [DW-1:0] src0_data;
    logic          src0_ready;
    logic          src1_valid;
    logic [DW-1:0] src1_data;
    logic          src1_ready;
    logic [DW-1:0] dac_data;
    logic [1:0]    grant;
    logic [UW-1:0] underrun_cnt;

    logic          lrc2;
    logic          en2;
    logic          s0r2;
    logic          s1r2;
    logic [7:0]    dac2;
    logic [1:0]    grant2;
    logic [3:0]    cnt2;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_tx[$];
    bit            en0_s;
    bit            en1_s;
    logic          lrc_prev;
    int            hs0;
    int            hs1;
    int            slot_r0;
    int            slot_r1;
    int            r0_log[$];
    int            r1_log[$];
    logic [1:0]    g_log[$];
    logic [UW-1:0] u_log[$];

    audio_dac_arbiter #(.DW(DW), .UW(UW)) dut (
        .aud_bclk    (aud_bclk),
        .rst         (rst),
        .aud_lrc     (aud_lrc),
        .en          (en),
        .src0_valid  (src0_valid),
        .src0_data   (src0_data),
        .src0_ready  (src0_ready),
        .src1_valid  (src1_valid),
        .src1_data   (src1_data),
        .src1_ready  (src1_ready),
        .dac_data    (dac_data),
        .grant       (grant),
        .underrun_cnt(underrun_cnt)
    );

    audio_dac_arbiter #(.DW(8), .UW(4)) dut_sat (
        .aud_bclk    (aud_bclk),
        .rst         (rst),
        .aud_lrc     (lrc2),
        .en          (en2),
        .src0_valid  (1'b0),
        .src0_data   (8'h00),
        .src0_ready  (s0r2),
        .src1_valid  (1'b0),
        .src1_data   (8'h00),
        .src1_ready  (s1r2),
        .dac_data    (dac2),
        .grant       (grant2),
        .underrun_cnt(cnt2)
    );

    initial begin
        aud_bclk = 1'b0;
        forever #5 aud_bclk = ~aud_bclk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // One bclk cycle: drive sources, sample outputs, score the transmitter latch on lrc edges.
    task automatic cyc();
        logic          take0;
        logic          take1;
        logic [DW-1:0] e;
        src0_valid = en0_s && (q0.size() > 0);
        src0_data  = (q0.size() > 0) ? q0[0] : '0;
        src1_valid = en1_s && (q1.size() > 0);
        src1_data  = (q1.size() > 0) ? q1[0] : '0;
        #1;
        total++;
        if (src0_ready && src1_ready) begin
            bad++;
            $display("FAIL both_ready t=%0t got=11 exp=at most one", $time);
        end
        if (aud_lrc != lrc_prev) begin
            total++;
            if (src0_ready || src1_ready) begin
                bad++;
                $display("FAIL edge_ready t=%0t got=%b%b exp=00", $time, src1_ready, src0_ready);
            end
            if (exp_tx.size() > 0) begin
                e = exp_tx.pop_front();
                total++;
                if (dac_data !== e) begin
                    bad++;
                    $display("FAIL tx_word t=%0t got=%h exp=%h", $time, dac_data, e);
                end
            end
        end
        take0 = src0_valid && src0_ready;
        take1 = src1_valid && src1_ready;
        if (src0_ready) slot_r0++;
        if (src1_ready) slot_r1++;
        lrc_prev = aud_lrc;
        @(posedge aud_bclk);
        if (take0) begin
            q0.delete(0);
            hs0++;
        end
        if (take1) begin
            q1.delete(0);
            hs1++;
        end
        #1;
    endtask

    task automatic run_slot(input bit e0, input bit e1, input int len);
        aud_lrc = ~aud_lrc;
        en0_s   = e0;
        en1_s   = e1;
        slot_r0 = 0;
        slot_r1 = 0;
        repeat (len) cyc();
        r0_log.push_back(slot_r0);
        r1_log.push_back(slot_r1);
        g_log.push_back(grant);
        u_log.push_back(underrun_cnt);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        aud_lrc    = 1'b0;
        en         = 1'b1;
        en0_s      = 1'b0;
        en1_s      = 1'b0;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        src0_data  = '0;
        src1_data  = '0;
        lrc2       = 1'b0;
        en2        = 1'b1;
        q0.delete();
        q1.delete();
        exp_tx.delete();
        r0_log.delete();
        r1_log.delete();
        g_log.delete();
        u_log.delete();
        hs0      = 0;
        hs1      = 0;
        lrc_prev = 1'b0;
        repeat (2) @(posedge aud_bclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        total++; if (dac_data !== '0) begin bad++; $display("FAIL rst_dac got=%h exp=0", dac_data); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
        total++; if (underrun_cnt !== '0) begin bad++; $display("FAIL rst_urun got=%h exp=0", underrun_cnt); end
        total++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready got=%b%b exp=00", src1_ready, src0_ready);
        end
        // aud_lrc high at release gives an immediate left fetch.
        aud_lrc = 1'b1;
        q0.push_back(32'h5A5A_5A5A);
        en0_s = 1'b1;
        @(posedge aud_bclk);
        #1;
        rst = 1'b0;
        repeat (3) cyc();
        total++; if (hs0 !== 1) begin bad++; $display("FAIL rel_fetch_hs got=%0d exp=1", hs0); end
        total++; if (dac_data !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rel_fetch_dac got=%h exp=5a5a5a5a", dac_data); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rel_fetch_grant got=%b exp=01", grant); end
    endtask

    task automatic test_single_src();
        do_reset();
        repeat (3) begin
            q0.push_back(32'h1111_1111);
            q0.push_back(32'h2222_2222);
        end
        exp_tx.push_back('0);
        repeat (2) begin
            exp_tx.push_back(32'h1111_1111);
            exp_tx.push_back(32'h2222_2222);
        end
        repeat (5) run_slot(1'b1, 1'b0, 32);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (r0_log[i] !== 1 || r1_log[i] !== 0) begin
                bad++; $display("FAIL single_ready_pulses slot=%0d got=%0d/%0d exp=1/0", i, r0_log[i], r1_log[i]);
            end
        end
        total++; if (g_log[1] !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", g_log[1]); end
        total++; if (underrun_cnt !== '0) begin bad++; $display("FAIL single_urun got=%0d exp=0", underrun_cnt); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL single_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            q0.push_back(32'hA000_0000 + k);
            q1.push_back(32'hB000_0000 + k);
        end
        exp_tx.push_back('0);
        exp_tx.push_back(32'hA000_0000); exp_tx.push_back(32'hA000_0001);
        exp_tx.push_back(32'hB000_0000); exp_tx.push_back(32'hB000_0001);
        exp_tx.push_back(32'hA000_0002); exp_tx.push_back(32'hA000_0003);
        exp_tx.push_back(32'hB000_0002); exp_tx.push_back(32'hB000_0003);
        repeat (9) run_slot(1'b1, 1'b1, 32);
        for (int i = 0; i < 8; i++) begin
            eg = (((i / 2) % 2) == 0) ? 2'b01 : 2'b10;
            total++;
            if (g_log[i] !== eg) begin bad++; $display("FAIL rr_grant slot=%0d got=%b exp=%b", i, g_log[i], eg); end
        end
        total++; if (underrun_cnt !== '0) begin bad++; $display("FAIL rr_urun got=%0d exp=0", underrun_cnt); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL rr_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_withdraw();
        do_reset();
        q1.push_back(32'hC000_0001);
        q1.push_back(32'hC000_0002);
        q0.push_back(32'hD000_0001);
        q0.push_back(32'hD000_0002);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hC000_0001);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hD000_0001);
        exp_tx.push_back(32'hD000_0002);
        run_slot(1'b0, 1'b1, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        total++; if (g_log[0] !== 2'b10) begin bad++; $display("FAIL wd_grant got=%b exp=10", g_log[0]); end
        total++; if (r0_log[1] !== 0) begin bad++; $display("FAIL wd_src0_ready got=%0d exp=0", r0_log[1]); end
        total++; if (r1_log[1] !== 31) begin bad++; $display("FAIL wd_src1_ready got=%0d exp=31", r1_log[1]); end
        total++; if (u_log[1] !== 16'd0) begin bad++; $display("FAIL wd_urun_before got=%0d exp=0", u_log[1]); end
        total++; if (u_log[4] !== 16'd1) begin bad++; $display("FAIL wd_urun got=%0d exp=1", u_log[4]); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL wd_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_edge_collision();
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back(32'hE000_0000 + k);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hE000_0000);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hE000_0001);
        exp_tx.push_back(32'hE000_0002);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b0, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        total++; if (u_log[2] !== 16'd1) begin bad++; $display("FAIL ec_urun got=%0d exp=1", u_log[2]); end
        total++; if (u_log[4] !== 16'd1) begin bad++; $display("FAIL ec_urun_end got=%0d exp=1", u_log[4]); end
        total++; if (hs0 !== 4) begin bad++; $display("FAIL ec_handshakes got=%0d exp=4", hs0); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL ec_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_enable();
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back(32'hF000_0000 + k);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hF000_0000);
        exp_tx.push_back('0);
        exp_tx.push_back('0);
        exp_tx.push_back('0);
        exp_tx.push_back(32'hF000_0001);
        run_slot(1'b1, 1'b0, 32);
        en = 1'b0;
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        en = 1'b1;
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        total++; if (g_log[1] !== 2'b00) begin bad++; $display("FAIL en_grant_off got=%b exp=00", g_log[1]); end
        total++; if (r0_log[1] + r0_log[2] + r0_log[3] !== 0) begin
            bad++; $display("FAIL en_ready_off got=%0d exp=0", r0_log[1] + r0_log[2] + r0_log[3]);
        end
        total++; if (u_log[3] !== 16'd0) begin bad++; $display("FAIL en_urun_off got=%0d exp=0", u_log[3]); end
        total++; if (u_log[4] !== 16'd1) begin bad++; $display("FAIL en_urun_resume got=%0d exp=1", u_log[4]); end
        total++; if (g_log[4] !== 2'b01) begin bad++; $display("FAIL en_grant_resume got=%b exp=01", g_log[4]); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL en_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back(32'h7000_0000 + k);
        exp_tx.push_back('0);
        exp_tx.push_back(32'h7000_0000);
        exp_tx.push_back('0);
        exp_tx.push_back(32'h7000_0001);
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b0, 1'b0, 10);
        total++; if (src0_ready !== 1'b1) begin bad++; $display("FAIL rm_pre_ready got=%b exp=1", src0_ready); end
        src0_valid = 1'b1;
        src0_data  = q0[0];
        rst        = 1'b1;
        #1;
        total++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
            bad++; $display("FAIL rm_ready got=%b%b exp=00", src1_ready, src0_ready);
        end
        total++; if (dac_data !== '0) begin bad++; $display("FAIL rm_dac got=%h exp=0", dac_data); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rm_grant got=%b exp=00", grant); end
        rst   = 1'b0;
        en0_s = 1'b1;
        repeat (22) cyc();
        total++; if (hs0 !== 1) begin bad++; $display("FAIL rm_consumed got=%0d exp=1", hs0); end
        run_slot(1'b1, 1'b0, 32);
        run_slot(1'b1, 1'b0, 32);
        total++; if (g_log[3] !== 2'b01) begin bad++; $display("FAIL rm_grant_after got=%b exp=01", g_log[3]); end
        total++; if (exp_tx.size() != 0) begin bad++; $display("FAIL rm_drain got=%0d exp=0", exp_tx.size()); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            lrc2 = ~lrc2;
            @(posedge aud_bclk);
            #1;
        end
        total++; if (cnt2 !== 4'd14) begin bad++; $display("FAIL sat_below got=%0d exp=14", cnt2); end
        lrc2 = ~lrc2;
        @(posedge aud_bclk);
        #1;
        total++; if (cnt2 !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d exp=15", cnt2); end
        repeat (5) begin
            lrc2 = ~lrc2;
            @(posedge aud_bclk);
            #1;
        end
        total++; if (cnt2 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", cnt2); end
        total++; if (dac2 !== 8'h00) begin bad++; $display("FAIL sat_mute got=%h exp=00", dac2); end
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_round_robin();
        test_withdraw();
        test_edge_collision();
        test_enable();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
